code_step_ctrl: RTL and testbench
=================================

# code_step_ctrl

Sequential controller that owns the 4-bit mode-selectable code register and steps it under start/stop/load control. It holds the current code, computes each next code with the counting rules below, checks the code against the active mode, and raises a fault on any illegal code. It is the sequencing block in front of the code-conversion datapath: its `code` and `mode` outputs drive that logic directly.

## Interface
- `DIV`, default 4: cycles per step while running; legal range 1..255.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_n` input 1: asynchronous reset, active low.
- `mode` input 1: counting rule. 0 = BCD, codes 0..9. 1 = binary mod-15, codes 0..14.
- `start` input 1: level; begin stepping.
- `stop` input 1: level; halt stepping.
- `load` input 1: one-cycle strobe; load `load_val`.
- `load_val` input 4: value written on `load`.
- `code` output 4: current code, registered.
- `valid` output 1: combinational from `code` and `mode`. High when `code` is legal for `mode`: ≤9 in mode 0, ≠15 in mode 1.
- `busy` output 1: high in RUN.
- `wrap` output 1: one-cycle pulse on the step that wraps to 0.
- `fault` output 1: high in FAULT.

## Operation
- There are three states: IDLE, RUN and FAULT.
- Prescaler `pcnt` is 8 bits wide. It counts 0..DIV-1 in RUN only.
- When `pcnt` is DIV-1, a step occurs and `pcnt` returns to 0. With DIV=1, a step occurs every cycle.
- Mode 0 step: codes 0→1→…→9→0. The 9→0 step pulses `wrap`.
- Mode 1 step: codes 0→1→…→14→0. The 14→0 step pulses `wrap`.
- Transitions, priority highest first:
  - `load`, any state: `code`←`load_val` and `pcnt`←0. Next state is FAULT if `load_val` is illegal for the current `mode`. Otherwise it is RUN if the block was already in RUN, else IDLE. `load` is the only way out of FAULT other than reset.
  - `stop` in RUN → IDLE. `code` and `pcnt` hold, then `pcnt`←0.
  - `start` in IDLE → RUN with `pcnt`←0.
  - In RUN, when `valid` is 0 (for example, `mode` changed to 0 while `code` > 9) → FAULT. No step occurs that cycle.
- `start` and `stop` in FAULT are ignored.
- If `start` and `stop` are high together in IDLE, the block stays in IDLE.
- `mode` may change at any time. The new rule applies to the next step.
- `code` never advances outside RUN.

## Timing
- Reset values: `code`=0, `pcnt`=0, state IDLE, `busy`=0, `wrap`=0, `fault`=0. `valid`=1, because code 0 is legal in both modes.
- Reset asserted mid-RUN forces all of the above immediately, without waiting for `clk`.
- `start` sampled at edge N: `busy`=1 after edge N. The first `code` change is after edge N+DIV.
- After that, `code` changes once every DIV cycles.
- `wrap` is registered. It is high for exactly the cycle after the wrapping edge, aligned with `code`=0.
- `load` sampled at edge N: `code`=`load_val` after edge N. `fault` updates after the same edge.
- Illegal code detected in RUN at edge N: `fault`=1 and `busy`=0 after edge N.
- `stop` sampled at edge N: `busy`=0 after edge N. Any step due at edge N is suppressed.

## Configuration
- Macro `CODE_STEP_DOWN_EN`.
- When defined, the block adds input `dir` (1 bit):
  - `dir`=1 steps downward: 0→9 in mode 0, 0→14 in mode 1.
  - The downward wrap out of 0 also pulses `wrap`.
  - `dir` is sampled at each step.
- When undefined, the `dir` port is absent and the block counts up only.

## Test plan
- Reset, then `start` with DIV=4, `mode`=0. Required:
  - `code` sequence 1,2,…,9,0 at cycles 4,8,…,40 after `start`.
  - `wrap` high exactly one cycle, with `code`=0.
- `mode`=1, load 13, then `start`. Required: `code` 14, then 0, with a `wrap` pulse. Code 15 never appears.
- In RUN, `mode`=1 and `code`=12; switch `mode` to 0. Required:
  - Next edge gives `fault`=1, `busy`=0, `code`=12, `valid`=0.
  - Then `load` 3: `fault`=0, IDLE, `code`=3.
- In IDLE, assert `load` 15 with `mode`=0. Required: FAULT, `code`=15. `start` then has no effect.
- In RUN, assert `load` and `stop` in the same cycle with `load_val`=5. Required: `code`=5, state RUN (load wins), `pcnt` restarted so the next step arrives DIV cycles later.
- With `CODE_STEP_DOWN_EN` defined, `dir`=1, `mode`=0, `code`=0, `start`. Required: after DIV cycles `code`=9 with `wrap` high for one cycle.

Source files
------------

// File: rtl/code_step_ctrl.sv
// Start/stop/load sequencer for the 4-bit BCD / mod-15 code register feeding the code converter.
// Optional build macro CODE_STEP_DOWN_EN adds a `dir` input for downward stepping.
module code_step_ctrl #(
  parameter int DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode,
  input  logic       start,
  input  logic       stop,
  input  logic       load,
  input  logic [3:0] load_val,
`ifdef CODE_STEP_DOWN_EN
  input  logic       dir,
`endif
  output logic [3:0] code,
  output logic       valid,
  output logic       busy,
  output logic       wrap,
  output logic       fault,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [7:0] PCNT_LAST = 8'(DIV - 1);

  state_t     state;
  logic [7:0] pcnt;
  logic       down;
  logic [3:0] step_code;
  logic       step_wrap;
  logic       load_legal;

`ifdef CODE_STEP_DOWN_EN
  assign down = dir;
`else
  assign down = 1'b0;
`endif

  function automatic logic is_legal(input logic [3:0] c, input logic m);
    return m ? (c != 4'd15) : (c <= 4'd9);
  endfunction

  assign valid      = is_legal(code, mode);
  assign load_legal = is_legal(load_val, mode);
  assign busy       = (state == RUN);
  assign fault      = (state == FAULT);
  assign state_dbg  = state;

  // Next code under the current mode; only used while code is legal, so the top is 9 or 14.
  always_comb begin
    step_code = code + 4'd1;
    step_wrap = 1'b0;
    if (down) begin
      if (code == 4'd0) begin
        step_code = mode ? 4'd14 : 4'd9;
        step_wrap = 1'b1;
      end else begin
        step_code = code - 4'd1;
      end
    end else if (code == (mode ? 4'd14 : 4'd9)) begin
      step_code = 4'd0;
      step_wrap = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      code  <= 4'd0;
      pcnt  <= 8'd0;
      wrap  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (load) begin
        code <= load_val;
        pcnt <= 8'd0;
        if (!load_legal)        state <= FAULT;
        else if (state == RUN)  state <= RUN;
        else                    state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start && !stop) begin
              state <= RUN;
              pcnt  <= 8'd0;
            end
          end
          RUN: begin
            if (stop) begin
              state <= IDLE;
              pcnt  <= 8'd0;
            end else if (!valid) begin
              // Mode switched under an out-of-range code: freeze the code and report it.
              state <= FAULT;
              pcnt  <= 8'd0;
            end else if (pcnt == PCNT_LAST) begin
              pcnt <= 8'd0;
              code <= step_code;
              wrap <= step_wrap;
            end else begin
              pcnt <= pcnt + 8'd1;
            end
          end
          FAULT: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_code_step_ctrl.sv
// Directed bench for code_step_ctrl (DIV=4): stepping, wrap, faults, load priority, async reset.
module tb_code_step_ctrl;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mode, start, stop, load;
  logic [3:0] load_val;
  logic [3:0] code;
  logic       valid, busy, wrap, fault;
  logic [1:0] state_dbg;
`ifdef CODE_STEP_DOWN_EN
  logic       dir;
`endif

  int checks = 0;
  int errors = 0;

  code_step_ctrl #(.DIV(DIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .start     (start),
    .stop      (stop),
    .load      (load),
    .load_val  (load_val),
`ifdef CODE_STEP_DOWN_EN
    .dir       (dir),
`endif
    .code      (code),
    .valid     (valid),
    .busy      (busy),
    .wrap      (wrap),
    .fault     (fault),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit so outputs are sampled away from the edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [3:0] v);
    load = 1'b1; load_val = v;
    tick();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; mode = 1'b0; start = 1'b0; stop = 1'b0; load = 1'b0; load_val = 4'd0;
`ifdef CODE_STEP_DOWN_EN
    dir = 1'b0;
`endif
    #12;
    check_eq("rst_code",  8'(code), 8'd0);
    check_eq("rst_busy",  8'(busy), 8'd0);
    check_eq("rst_wrap",  8'(wrap), 8'd0);
    check_eq("rst_fault", 8'(fault), 8'd0);
    check_eq("rst_valid", 8'(valid), 8'd1);
    check_eq("rst_state", 8'(state_dbg), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // BCD run: code k after 4k edges, wrap alongside code 0
    do_start();
    check_eq("start_busy", 8'(busy), 8'd1);
    check_eq("start_code", 8'(code), 8'd0);
    for (int k = 1; k <= 10; k++) begin
      tick(DIV - 1);
      check_eq("bcd_hold", 8'(code), 8'(k - 1));
      tick();
      check_eq("bcd_code", 8'(code), 8'(k % 10));
      check_eq("bcd_wrap", 8'(wrap), (k == 10) ? 8'd1 : 8'd0);
    end
    tick();
    check_eq("bcd_wrap_end", 8'(wrap), 8'd0);
    do_stop();
    check_eq("stop_busy", 8'(busy), 8'd0);

    // Mod-15 wrap from 13
    mode = 1'b1;
    do_load(4'd13);
    check_eq("m1_load_code",  8'(code), 8'd13);
    check_eq("m1_load_state", 8'(state_dbg), 8'd0);
    do_start();
    for (int i = 0; i < 2 * DIV; i++) begin
      tick();
      check_eq("m1_no15", 8'(code == 4'd15), 8'd0);
      if (i == DIV - 1) begin
        check_eq("m1_code14", 8'(code), 8'd14);
        check_eq("m1_wrap0",  8'(wrap), 8'd0);
      end
    end
    check_eq("m1_code0", 8'(code), 8'd0);
    check_eq("m1_wrap",  8'(wrap), 8'd1);
    do_stop();

    // Mode switch under code 12 while running -> FAULT
    do_load(4'd12);
    do_start();
    mode = 1'b0;
    #1;
    check_eq("sw_valid_pre", 8'(valid), 8'd0);
    tick();
    check_eq("sw_fault", 8'(fault), 8'd1);
    check_eq("sw_busy",  8'(busy), 8'd0);
    check_eq("sw_code",  8'(code), 8'd12);
    check_eq("sw_valid", 8'(valid), 8'd0);
    do_load(4'd3);
    check_eq("rec_fault", 8'(fault), 8'd0);
    check_eq("rec_state", 8'(state_dbg), 8'd0);
    check_eq("rec_code",  8'(code), 8'd3);

    // Illegal load in IDLE; start ignored in FAULT
    do_load(4'd15);
    check_eq("ill_state", 8'(state_dbg), 8'd2);
    check_eq("ill_code",  8'(code), 8'd15);
    start = 1'b1;
    tick(2 * DIV);
    start = 1'b0;
    check_eq("ill_start_busy",  8'(busy), 8'd0);
    check_eq("ill_start_fault", 8'(fault), 8'd1);
    check_eq("ill_start_code",  8'(code), 8'd15);
    do_load(4'd0);
    check_eq("ill_exit_state", 8'(state_dbg), 8'd0);

    // start+stop together in IDLE stays IDLE
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check_eq("ss_idle", 8'(state_dbg), 8'd0);

    // load wins over stop in RUN; prescaler restarts
    do_start();
    tick(2);
    load = 1'b1; stop = 1'b1; load_val = 4'd5;
    tick();
    load = 1'b0; stop = 1'b0;
    check_eq("ls_code",  8'(code), 8'd5);
    check_eq("ls_state", 8'(state_dbg), 8'd1);
    tick(DIV - 1);
    check_eq("ls_hold", 8'(code), 8'd5);
    tick();
    check_eq("ls_step", 8'(code), 8'd6);

    // stop on the edge a step is due suppresses it
    tick(DIV - 1);
    do_stop();
    check_eq("sup_code", 8'(code), 8'd6);
    check_eq("sup_busy", 8'(busy), 8'd0);
    tick(2 * DIV);
    check_eq("idle_hold", 8'(code), 8'd6);

    // async reset mid-run acts without a clock edge
    do_start();
    tick(DIV);
    check_eq("pre_rst_code", 8'(code), 8'd7);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_code",  8'(code), 8'd0);
    check_eq("arst_busy",  8'(busy), 8'd0);
    check_eq("arst_state", 8'(state_dbg), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

`ifdef CODE_STEP_DOWN_EN
    dir = 1'b1;
    do_start();
    tick(DIV);
    check_eq("dn_code", 8'(code), 8'd9);
    check_eq("dn_wrap", 8'(wrap), 8'd1);
    tick();
    check_eq("dn_wrap_end", 8'(wrap), 8'd0);
    tick(DIV - 1);
    check_eq("dn_code8", 8'(code), 8'd8);
    do_stop();
    dir = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got 0 exp 1");
    $fatal(1, "timeout");
  end

endmodule
